// File: rtl/instruction_memory.sv
// instruction_memory: fetch-side responder returning 32-bit instruction words
// over a valid/ready response channel, with optional wait states and a
// write-only load port for filling the program image.
//
// Optional feature: define INSTRUCTION_MEMORY_FAULT_EN to flag misaligned or
// out-of-range fetch addresses on o_ResponseFault (instruction forced to 0).
// Without it, the low address bits are ignored and the word index wraps.
module instruction_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_RequestValid,
  output logic        o_RequestReady,
  input  logic [31:0] i_RequestAddress,
  output logic        o_ResponseValid,
  input  logic        i_ResponseReady,
  output logic [31:0] o_ResponseInstruction,
  output logic [31:0] o_ResponseAddress,
  output logic        o_ResponseFault,
  input  logic        i_LoadEnable,
  input  logic [31:0] i_LoadAddress,
  input  logic [31:0] i_LoadData
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_nxt;
  logic              req_hs;
  logic              rsp_hs;
  logic              accept;
  logic              do_read;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       addr_q;
  logic [31:0]       instr_q;
  logic              fault_q;

  logic [31:0]       rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_word;
  logic              rd_fault;
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_in_range;
  logic              unused_bits;

  assign o_RequestReady        = (state_q == S_IDLE) | ((state_q == S_RESP) & i_ResponseReady);
  assign o_ResponseValid       = (state_q == S_RESP);
  assign o_ResponseInstruction = instr_q;
  assign o_ResponseAddress     = addr_q;
  assign o_ResponseFault       = fault_q;

  assign req_hs = i_RequestValid & o_RequestReady;
  assign rsp_hs = o_ResponseValid & i_ResponseReady;

  // With no wait states the array is read on the accepting edge, so the live
  // request address selects the word; otherwise the captured address does.
  // Either way the read result lands in a register, so there is no
  // combinational path from the request address to the response outputs.
  assign rd_addr = (WAIT_STATES == 0) ? i_RequestAddress : addr_q;
  assign rd_idx  = rd_addr[IDX_W+1:2];
  assign rd_word = mem[rd_idx];

`ifdef INSTRUCTION_MEMORY_FAULT_EN
  assign rd_fault = (rd_addr[1:0] != 2'b00) | ({2'b00, rd_addr[31:2]} >= DEPTH_LIMIT);
`else
  assign rd_fault = 1'b0;
`endif

  assign ld_idx      = i_LoadAddress[IDX_W+1:2];
  assign ld_in_range = ({2'b00, i_LoadAddress[31:2]} < DEPTH_LIMIT);

  // Address bits that only matter when fault detection is built in.
  assign unused_bits = ^{rd_addr, i_LoadAddress[1:0]};

  // Next-state, wait counter and read/capture strobes
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    accept    = 1'b0;
    do_read   = 1'b0;
    case (state_q)
      S_IDLE: accept = req_hs;
      S_WAIT: begin
        cnt_nxt = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_read   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          accept    = req_hs;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A newly accepted request overrides the default successor above.
    if (accept) begin
      if (WAIT_STATES == 0) begin
        do_read   = 1'b1;
        state_nxt = S_RESP;
      end else begin
        cnt_nxt   = WAIT_LOAD;
        state_nxt = S_WAIT;
      end
    end
  end

  // State, counter and response registers; reset drops any in-flight request
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      instr_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (accept) begin
        addr_q <= i_RequestAddress;
      end
      if (do_read) begin
        instr_q <= rd_fault ? 32'd0 : rd_word;
        fault_q <= rd_fault;
      end
    end
  end

  // Program load; non-blocking write keeps same-edge reads on the old word
  always_ff @(posedge i_Clock) begin
    if (i_LoadEnable && ld_in_range) begin
      mem[ld_idx] <= i_LoadData;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: three instances (0, 2 and 3 wait states) driven by
// directed scenarios and then randomized traffic, each compared every cycle
// against a transaction-level model of the fetch protocol.
module tb_instruction_memory;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [NI];
  logic [31:0] req_addr  [NI];
  logic        rsp_ready [NI];
  logic        rdy_o     [NI];
  logic        vld_o     [NI];
  logic        flt_o     [NI];
  logic [31:0] ins_o     [NI];
  logic [31:0] adr_o     [NI];
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic [31:0] mmem [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Expected {fault, instruction} for a fetch of byte address a.
  function automatic logic [32:0] exp_resp(input logic [31:0] a);
    int unsigned wi;
    wi = a >> 2;
`ifdef INSTRUCTION_MEMORY_FAULT_EN
    if ((a % 4) != 0 || wi >= DEPTH) return {1'b1, 32'h0};
    return {1'b0, mmem[wi]};
`else
    return {1'b0, mmem[wi % DEPTH]};
`endif
  endfunction

  // Reference memory: loads beyond the array are dropped.
  always @(posedge clk) begin
    if (ld_en && (ld_addr >> 2) < DEPTH) mmem[(ld_addr >> 2) % DEPTH] <= ld_data;
  end

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;

    instruction_memory #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
      .i_Clock              (clk),
      .i_Reset              (rst),
      .i_RequestValid       (req_valid[g]),
      .o_RequestReady       (rdy_o[g]),
      .i_RequestAddress     (req_addr[g]),
      .o_ResponseValid      (vld_o[g]),
      .i_ResponseReady      (rsp_ready[g]),
      .o_ResponseInstruction(ins_o[g]),
      .o_ResponseAddress    (adr_o[g]),
      .o_ResponseFault      (flt_o[g]),
      .i_LoadEnable         (ld_en),
      .i_LoadAddress        (ld_addr),
      .i_LoadData           (ld_data)
    );

    // Transaction model: one request outstanding, answered W cycles after
    // acceptance, held until consumed.
    bit          m_out;
    bit          m_vld;
    bit          m_acc;
    int          m_rem;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic        m_fault;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_out = 0; m_vld = 0; m_rem = 0;
        m_addr = 32'h0; m_instr = 32'h0; m_fault = 1'b0;
      end else begin
        m_acc = req_valid[g] && (!m_out || (m_vld && rsp_ready[g]));
        if (m_vld && rsp_ready[g]) begin
          m_vld = 0;
          m_out = 0;
        end
        if (m_acc) begin
          m_out  = 1;
          m_addr = req_addr[g];
          if (W == 0) begin
            {m_fault, m_instr} = exp_resp(m_addr);
            m_vld = 1;
          end else begin
            m_rem = W;
          end
        end else if (m_out && !m_vld) begin
          m_rem--;
          if (m_rem == 0) begin
            {m_fault, m_instr} = exp_resp(m_addr);
            m_vld = 1;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        check($sformatf("g%0d ready", g), rdy_o[g], (!m_out || (m_vld && rsp_ready[g])));
        check($sformatf("g%0d valid", g), vld_o[g], m_vld);
        check($sformatf("g%0d addr", g), adr_o[g], m_addr);
        if (m_vld) begin
          check($sformatf("g%0d instr", g), ins_o[g], m_instr);
          check($sformatf("g%0d fault", g), flt_o[g], m_fault);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int g, input int limit, input string nm);
    int n;
    n = 0;
    while (vld_o[g] !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(nm, vld_o[g], 1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0, 1:    return ($urandom % DEPTH) * 4;
      2:       return $urandom % (DEPTH * 4 + 16);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] prog [4];
  logic [31:0] exp_i0, exp_i1;
  logic        exp_f;

  initial begin
    prog[0] = 32'h00000013; prog[1] = 32'h00100093;
    prog[2] = 32'h00208113; prog[3] = 32'h00310193;
    for (int g = 0; g < NI; g++) begin
      req_valid[g] = 1'b0; req_addr[g] = 32'h0; rsp_ready[g] = 1'b1;
    end
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;

    // Reset values
    tick(); tick();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("g%0d reset ready", g), rdy_o[g], 1);
      check($sformatf("g%0d reset valid", g), vld_o[g], 0);
      check($sformatf("g%0d reset instr", g), ins_o[g], 0);
      check($sformatf("g%0d reset addr", g), adr_o[g], 0);
      check($sformatf("g%0d reset fault", g), flt_o[g], 0);
    end
    rst = 1'b0;

    // Fill the program image; low address bits are ignored
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      ld_en = 1'b1;
      ld_addr = i * 4 + ($urandom % 4);
      ld_data = (i < 4) ? prog[i] : $urandom;
    end
    // Out-of-range load aliasing word 0 must be dropped
    tick();
    ld_addr = DEPTH * 4; ld_data = 32'hCAFEF00D;
    tick();
    ld_en = 1'b0;

    // Back-to-back fetch, no wait states
    for (int k = 0; k <= 4; k++) begin
      tick();
      req_valid[0] = (k < 4);
      req_addr[0] = k * 4;
      if (k > 0) begin
        @(negedge clk);
        check("b2b valid", vld_o[0], 1);
        check("b2b instr", ins_o[0], prog[k-1]);
        check("b2b addr", adr_o[0], (k - 1) * 4);
      end
    end

    // Two wait states: ready low while waiting, data after E+2
    tick();
    req_valid[1] = 1'b1; req_addr[1] = 32'h4;
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("ws valid E", vld_o[1], 0);
    check("ws ready E", rdy_o[1], 0);
    tick();
    @(negedge clk);
    check("ws valid E+1", vld_o[1], 0);
    check("ws ready E+1", rdy_o[1], 0);
    tick();
    @(negedge clk);
    check("ws valid E+2", vld_o[1], 1);
    check("ws instr", ins_o[1], 32'h00100093);
    tick();

    // Backpressure: response held five cycles, new request not accepted
    rsp_ready[1] = 1'b0; req_valid[1] = 1'b1; req_addr[1] = 32'h8;
    tick();
    req_addr[1] = 32'hC;
    wait_valid(1, 10, "bp response timeout");
    for (int k = 0; k < 5; k++) begin
      check("bp valid", vld_o[1], 1);
      check("bp instr", ins_o[1], 32'h00208113);
      check("bp addr", adr_o[1], 32'h8);
      check("bp ready", rdy_o[1], 0);
      @(negedge clk);
    end
    tick();
    rsp_ready[1] = 1'b1; req_valid[1] = 1'b0;
    @(negedge clk);
    check("bp release ready", rdy_o[1], 1);
    tick();
    @(negedge clk);
    check("bp idle valid", vld_o[1], 0);
    check("bp idle ready", rdy_o[1], 1);

    // Misaligned and out-of-range fetches
`ifdef INSTRUCTION_MEMORY_FAULT_EN
    exp_i0 = 32'h0; exp_i1 = 32'h0; exp_f = 1'b1;
`else
    exp_i0 = 32'h00100093; exp_i1 = 32'h00000013; exp_f = 1'b0;
`endif
    tick();
    req_valid[0] = 1'b1; req_addr[0] = 32'h6;
    tick();
    req_addr[0] = DEPTH * 4;
    @(negedge clk);
    check("fault 0x6 instr", ins_o[0], exp_i0);
    check("fault 0x6 flag", flt_o[0], exp_f);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("fault oor instr", ins_o[0], exp_i1);
    check("fault oor flag", flt_o[0], exp_f);

    // Reset while waiting, after a completed fetch left data in the registers
    tick();
    req_valid[2] = 1'b1; req_addr[2] = 32'h8;
    tick();
    req_valid[2] = 1'b0;
    wait_valid(2, 10, "pre-reset response timeout");
    tick();
    req_valid[2] = 1'b1; req_addr[2] = 32'h4;
    tick();
    req_valid[2] = 1'b0;
    tick();
    check("pre-reset instr", ins_o[2], 32'h00208113);
    check("pre-reset ready", rdy_o[2], 0);
    rst = 1'b1;
    #1;
    check("async reset valid", vld_o[2], 0);
    check("async reset instr", ins_o[2], 0);
    check("async reset addr", adr_o[2], 0);
    check("async reset fault", flt_o[2], 0);
    check("async reset ready", rdy_o[2], 1);
    tick();
    rst = 1'b0;
    tick();
    req_valid[2] = 1'b1; req_addr[2] = 32'h4;
    tick();
    req_valid[2] = 1'b0;
    wait_valid(2, 10, "post-reset response timeout");
    check("post-reset instr", ins_o[2], 32'h00100093);

    // Load and read of the same word on one edge
    tick();
    req_valid[0] = 1'b1; req_addr[0] = 32'h4;
    ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEADBEEF;
    tick();
    req_valid[0] = 1'b0; ld_en = 1'b0;
    @(negedge clk);
    check("collision old data", ins_o[0], 32'h00100093);
    tick();
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("collision new data", ins_o[0], 32'hDEADBEEF);

    // Randomized traffic on all instances, occasional async reset
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        req_valid[g] = ($urandom % 2) == 0;
        req_addr[g]  = rand_addr();
        rsp_ready[g] = ($urandom % 4) != 0;
      end
      ld_en   = ($urandom % 5) == 0;
      ld_addr = rand_addr();
      ld_data = $urandom;
      rst     = ($urandom % 400) == 0;
    end
    tick();
    rst = 1'b0; ld_en = 1'b0;
    for (int g = 0; g < NI; g++) begin
      req_valid[g] = 1'b0;
      rsp_ready[g] = 1'b1;
    end
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Instruction-side responder for the core's fetch path. It consumes the byte address driven by the program counter and returns the 32-bit instruction word stored at that address over a valid/ready response channel. Configurable wait states model slower memory. A write-only load port fills the program from the bench or boot logic.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 2.
- WAIT_STATES, 0, extra cycles between request acceptance and response; range 0..15.
- i_Clock  in  1  sole clock; all state updates on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_RequestValid  in  1  a fetch address is presented.
- o_RequestReady  out  1  the block accepts a request this cycle.
- i_RequestAddress  in  32  byte address of the instruction.
- o_ResponseValid  out  1  response fields are valid.
- i_ResponseReady  in  1  the consumer accepts the response this cycle.
- o_ResponseInstruction  out  32  instruction word.
- o_ResponseAddress  out  32  echo of the accepted request address.
- o_ResponseFault  out  1  bad fetch address (see Configuration).
- i_LoadEnable  in  1  write i_LoadData into the memory this cycle.
- i_LoadAddress  in  32  byte address of the load; bits [1:0] ignored.
- i_LoadData  in  32  word to store.

## Operation
- Storage: DEPTH_WORDS x 32 array. Word index is address[$clog2(DEPTH_WORDS)+1:2]. Reset does not clear the array.
- States:
  - IDLE: no request outstanding.
  - WAIT: waiting out the configured wait states.
  - RESP: response presented.
- Transitions:
  - IDLE, request handshake, WAIT_STATES=0: read the array, go to RESP.
  - IDLE, request handshake, WAIT_STATES>0: load the 4-bit wait counter with WAIT_STATES, go to WAIT.
  - WAIT: the counter decrements each cycle. On the cycle it equals 1, read the array and go to RESP.
  - RESP, response handshake with no new request: go to IDLE.
  - RESP, response handshake with a new request handshake in the same cycle: the new request is accepted. The next state follows the IDLE rules above.
- o_RequestReady = (state==IDLE) | (state==RESP & i_ResponseReady). It is low throughout WAIT.
- Handshake rule: a transfer occurs when valid and ready are both high at a rising edge.
- Response hold: while o_ResponseValid=1 and i_ResponseReady=0, all response outputs hold stable.
- Address capture: the accepted address is registered and driven on o_ResponseAddress until the next acceptance.
- Load port: writes on the rising edge whenever i_LoadEnable=1, in any state.
  - Loads whose address is out of range are dropped.
  - Read-before-write: a read and a load to the same word on the same edge returns the old data.

## Timing
- Reset values: o_ResponseValid=0, o_ResponseInstruction=0, o_ResponseAddress=0, o_ResponseFault=0, state=IDLE, counter=0.
- o_RequestReady is 1 in IDLE, so it is 1 during reset.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge. Any in-flight request is discarded.
- Latency: a request accepted at edge E raises o_ResponseValid in the cycle after edge E+WAIT_STATES.
- Throughput:
  - WAIT_STATES=0 with i_ResponseReady held high: one response per cycle.
  - Otherwise: one response per WAIT_STATES+1 cycles.
- No combinational path from i_RequestAddress to any response output.

## Configuration
- Macro INSTRUCTION_MEMORY_FAULT_EN.
- Defined:
  - o_ResponseFault=1 when address[1:0]!=0 or when address>>2 >= DEPTH_WORDS.
  - On a faulting fetch, o_ResponseInstruction=32'h00000000.
  - Latency and handshake are unchanged.
- Undefined:
  - o_ResponseFault is tied to 0.
  - Address bits [1:0] are ignored.
  - The word index wraps modulo DEPTH_WORDS.

## Test plan
- Back-to-back fetch:
  - Stimulus: WAIT_STATES=0. Load words 0..3 = 00000013, 00100093, 00208113, 00310193. Request 0x0, 0x4, 0x8, 0xC on consecutive cycles with i_ResponseReady=1.
  - Response: four consecutive response cycles, each with the matching word and echoed address.
- Wait states:
  - Stimulus: WAIT_STATES=2, request 0x4 accepted at edge E.
  - Response: o_RequestReady=0 during WAIT. o_ResponseValid rises after edge E+2 with 00100093.
- Backpressure:
  - Stimulus: i_ResponseReady=0 for 5 cycles during RESP.
  - Response: valid, instruction and address held stable and o_RequestReady=0. Raising ready completes the transfer and returns the block to IDLE.
- Faults:
  - Stimulus: with the macro defined, request 0x6, then request 4*DEPTH_WORDS. Repeat with the macro undefined.
  - Response with the macro: both fetches return fault=1 and instruction 0.
  - Response without the macro: 0x6 returns word 1 and 4*DEPTH_WORDS returns word 0, both with fault=0.
- Reset during WAIT:
  - Stimulus: WAIT_STATES=3, assert i_Reset mid-WAIT.
  - Response: all outputs go to reset values without a clock edge. After release, a request to 0x4 still returns 00100093.
- Load/read collision:
  - Stimulus: WAIT_STATES=0. Load word 1 = DEADBEEF on the same edge that accepts request 0x4.
  - Response: the first response returns 00100093. The next read of 0x4 returns DEADBEEF.
